// File: rtl/seg_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the two-digit seven-segment scan driver.
//   SEG_0..SEG_9 : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments dark
//   AN_OFF       : all anodes disabled (active-low)
//   AN_ONES/TENS : anode enable for the ones / tens digit
//   slot_e       : scan slot (ONES, TENS)
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } slot_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg_scan_driver_if
// Bundles the value input and the display outputs of the scan driver.
//   count : 4-bit binary value from the upstream counter
//   an    : anode enables, active-low
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low
// Modports: master = upstream/display side, slave = the driver.
// ----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic [3:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output count, input an, input seg, input dp);
    modport slave  (input count, output an, output seg, output dp);
endinterface

// File: rtl/seg_scan_driver_decoder.sv
// ----------------------------------------------------------------------------
// seg_decoder
// Combinational BCD digit to active-low seven-segment pattern.
//   bcd_i : 4-bit digit, 0-9 decoded, 10-15 give a blank pattern
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
// Two-digit multiplexed seven-segment driver for a common-anode, active-low
// display. Shows a 0-15 binary value as decimal tens/ones, alternating the
// two digits every REFRESH_DIV clocks. The value is sampled only at the end
// of the tens slot so a frame never mixes two values.
//   clk   : board clock
//   Clear : asynchronous active-high reset
//   bus   : seg_scan_driver_if.slave (count in, an/seg/dp out)
// Parameter REFRESH_DIV (>= 2): clocks per digit slot.
// Optional macro SEG_LEADING_ZERO_BLANK_EN: darken the tens digit when it
// would show 0.
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)(
    input  logic          clk,
    input  logic          Clear,
    seg_scan_driver_if.slave bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] RCNT_TC = RW'(REFRESH_DIV - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    slot_e         slot_q, slot_d;
    logic [3:0]    hv_q,   hv_d;
    logic [3:0]    an_q,   an_d;
    logic [6:0]    seg_q,  seg_d;

    logic          tc;
    logic          tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic [6:0]    digit_seg;

    assign tc = (rcnt_q == RCNT_TC);

    // Binary to BCD: value is at most 15, so tens is a single bit.
    assign tens  = (hv_q >= 4'd10);
    assign ones  = tens ? (hv_q - 4'd10) : hv_q;
    assign digit = (slot_q == TENS) ? {3'b000, tens} : ones;

    seg_decoder u_dec (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    // State register (scan FSM plus refresh counter and held value)
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            rcnt_q <= '0;
            slot_q <= ONES;
            hv_q   <= 4'd0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
        end else begin
            rcnt_q <= rcnt_d;
            slot_q <= slot_d;
            hv_q   <= hv_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    // Next-state logic
    always_comb begin
        rcnt_d = tc ? '0 : rcnt_q + 1'b1;
        slot_d = slot_q;
        hv_d   = hv_q;
        if (tc) begin
            slot_d = (slot_q == ONES) ? TENS : ONES;
            // Capture only at the frame boundary (end of the tens slot).
            if (slot_q == TENS) begin
                hv_d = bus.count;
            end
        end
    end

    // Output logic, registered so an/seg follow slot/hv by one edge
    always_comb begin
        an_d  = AN_ONES;
        seg_d = digit_seg;
        if (slot_q == TENS) begin
            an_d = AN_TENS;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (!tens) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int R = 4;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] T0_SEG = 7'b1111111;
    localparam logic [3:0] T0_AN  = 4'b1111;
`else
    localparam logic [6:0] T0_SEG = 7'b1000000;
    localparam logic [3:0] T0_AN  = 4'b1101;
`endif

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic [3:0] tens_an;
    } vec_t;

    logic clk = 1'b0;
    logic Clear;
    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.REFRESH_DIV(R)) dut (
        .clk   (clk),
        .Clear (Clear),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int n     = 0;   // edges since reset release
    int hv_m  = 0;   // model's held value
    vec_t tbl [16];

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1000000;
            1: pat = 7'b1111001;
            2: pat = 7'b0100100;
            3: pat = 7'b0110000;
            4: pat = 7'b0011001;
            5: pat = 7'b0010010;
            6: pat = 7'b0000010;
            7: pat = 7'b1111000;
            8: pat = 7'b0000000;
            9: pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, n);
        end
    endtask

    // One clock edge, then compare against the model.
    task automatic step();
        int c_at, sl, t, o;
        logic [6:0] es;
        logic [3:0] ea;
        c_at = int'(bus.count);
        @(posedge clk);
        #1;
        if (Clear) begin
            chk("held_clear_an", {3'b000, bus.an}, 7'b0001111);
            chk("held_clear_seg", bus.seg, 7'b1111111);
        end else begin
            n++;
            sl = ((n - 1) / R) % 2;
            t  = (hv_m >= 10) ? 1 : 0;
            o  = hv_m - 10 * t;
            if (sl == 0) begin
                ea = 4'b1110;
                es = pat(o);
            end else begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (t == 0) begin
                    ea = 4'b1111;
                    es = 7'b1111111;
                end else begin
                    ea = 4'b1101;
                    es = pat(t);
                end
`else
                ea = 4'b1101;
                es = pat(t);
`endif
            end
            chk("model_an", {3'b000, bus.an}, {3'b000, ea});
            chk("model_seg", bus.seg, es);
            if (n % (2 * R) == 0) hv_m = c_at;
        end
        chk("dp", {6'b0, bus.dp}, 7'b0000001);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Called at posedge+1: assert Clear between edges, verify immediate blank.
    task automatic do_reset();
        Clear = 1'b1;
        #1;
        chk("async_clear_an", {3'b000, bus.an}, 7'b0001111);
        chk("async_clear_seg", bus.seg, 7'b1111111);
        run(2);
        Clear = 1'b0;
        n     = 0;
        hv_m  = 0;
    endtask

    initial begin
        tbl[0]  = '{4'd0,  7'b1000000, T0_SEG,     T0_AN};
        tbl[1]  = '{4'd1,  7'b1111001, T0_SEG,     T0_AN};
        tbl[2]  = '{4'd2,  7'b0100100, T0_SEG,     T0_AN};
        tbl[3]  = '{4'd3,  7'b0110000, T0_SEG,     T0_AN};
        tbl[4]  = '{4'd4,  7'b0011001, T0_SEG,     T0_AN};
        tbl[5]  = '{4'd5,  7'b0010010, T0_SEG,     T0_AN};
        tbl[6]  = '{4'd6,  7'b0000010, T0_SEG,     T0_AN};
        tbl[7]  = '{4'd7,  7'b1111000, T0_SEG,     T0_AN};
        tbl[8]  = '{4'd8,  7'b0000000, T0_SEG,     T0_AN};
        tbl[9]  = '{4'd9,  7'b0010000, T0_SEG,     T0_AN};
        tbl[10] = '{4'd10, 7'b1000000, 7'b1111001, 4'b1101};
        tbl[11] = '{4'd11, 7'b1111001, 7'b1111001, 4'b1101};
        tbl[12] = '{4'd12, 7'b0100100, 7'b1111001, 4'b1101};
        tbl[13] = '{4'd13, 7'b0110000, 7'b1111001, 4'b1101};
        tbl[14] = '{4'd14, 7'b0011001, 7'b1111001, 4'b1101};
        tbl[15] = '{4'd15, 7'b0010010, 7'b1111001, 4'b1101};

        Clear     = 1'b0;
        bus.count = 4'd0;
        #2;
        Clear = 1'b1;
        #1;
        chk("reset_an", {3'b000, bus.an}, 7'b0001111);
        chk("reset_seg", bus.seg, 7'b1111111);
        chk("reset_dp", {6'b0, bus.dp}, 7'b0000001);
        run(3);
        Clear = 1'b0;
        n = 0; hv_m = 0;

        // count = 9 from reset
        bus.count = 4'd9;
        run(1);
        chk("first_edge_an", {3'b000, bus.an}, 7'b0001110);
        chk("first_edge_seg", bus.seg, 7'b1000000);
        run(2 * R);
        chk("cnt9_ones_an", {3'b000, bus.an}, 7'b0001110);
        chk("cnt9_ones_seg", bus.seg, 7'b0010000);
        run(R);
        chk("cnt9_tens_an", {3'b000, bus.an}, {3'b000, T0_AN});
        chk("cnt9_tens_seg", bus.seg, T0_SEG);

        // Table: every input value, ones slot then tens slot of the first captured frame
        for (int i = 0; i < 16; i++) begin
            do_reset();
            bus.count = tbl[i].cnt;
            run(2 * R + 1);
            chk($sformatf("tbl%0d_ones_an", i), {3'b000, bus.an}, 7'b0001110);
            chk($sformatf("tbl%0d_ones_seg", i), bus.seg, tbl[i].ones_seg);
            run(R - 1);
            chk($sformatf("tbl%0d_ones_len", i), {3'b000, bus.an}, 7'b0001110);
            run(1);
            chk($sformatf("tbl%0d_tens_an", i), {3'b000, bus.an}, {3'b000, tbl[i].tens_an});
            chk($sformatf("tbl%0d_tens_seg", i), bus.seg, tbl[i].tens_seg);
        end

        // Mid-frame change is held off until the next frame boundary
        do_reset();
        bus.count = 4'd5;
        run(2 * R + R + 1);
        bus.count = 4'd11;
        run(1);
        chk("midchg_tens_seg", bus.seg, T0_SEG);
        run(2 * R - (R + 2));
        run(1);
        chk("midchg_ones_seg", bus.seg, 7'b1111001);
        run(R);
        chk("midchg_tens_an", {3'b000, bus.an}, 7'b0001101);
        chk("midchg_tens_seg2", bus.seg, 7'b1111001);

        // Clear pulsed mid-tens slot
        bus.count = 4'd15;
        do_reset();
        run(2 * R + R + 1);
        #2;
        Clear = 1'b1;
        #1;
        chk("midclr_an", {3'b000, bus.an}, 7'b0001111);
        chk("midclr_seg", bus.seg, 7'b1111111);
        run(1);
        Clear = 1'b0;
        n = 0; hv_m = 0;
        for (int i = 0; i < R; i++) begin
            run(1);
            chk("midclr_ones_an", {3'b000, bus.an}, 7'b0001110);
            chk("midclr_ones_seg", bus.seg, 7'b1000000);
        end
        run(1);
        chk("midclr_tens_an", {3'b000, bus.an}, {3'b000, T0_AN});

        // Randomized count changes against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 5) == 0) bus.count = 4'($urandom_range(0, 15));
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
